// File: rtl/kisc_pkg.sv
// kisc_pkg: shared ALU mode codes, RV32I opcodes, immediate formats and the issue entry type
package kisc_pkg;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {IMM_I, IMM_U} imm_fmt_e;

    typedef struct packed {
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic        illegal;
    } alu_entry_t;

    function automatic logic [31:0] imm_of(input imm_fmt_e fmt, input logic [31:0] instr);
        return fmt == IMM_U ? {instr[31:12], 12'b0} : {{20{instr[31]}}, instr[31:20]};
    endfunction
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational RV32I decode into ALU mode and operands
// Ports: instr/pc/rs1/rs2 in; m, a, b, rd, wen, illegal out.
// Legality checking only exists when ALU_ISSUE_ILLEGAL_EN is defined.
module alu_op_decode
    import kisc_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [3:0]  m,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [4:0]  rd,
    output logic        wen,
    output logic        illegal
);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [3:0]  m_d;
    logic [31:0] a_d;
    logic [31:0] b_d;
    logic        bad;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign rd  = instr[11:7];

    // Unknown opcodes fall through as an add of rs1 and rs2.
    always_comb begin
        m_d = ALU_ADD;
        a_d = rs1;
        b_d = rs2;
        case (opc)
            OPC_OP:            m_d = {instr[30], f3};
            OPC_OP_IMM: begin
                m_d = {f3 == 3'b101 && instr[30], f3};
                b_d = imm_of(IMM_I, instr);
            end
            OPC_LUI: begin
                a_d = '0;
                b_d = imm_of(IMM_U, instr);
            end
            OPC_AUIPC: begin
                a_d = pc;
                b_d = imm_of(IMM_U, instr);
            end
            OPC_JAL, OPC_JALR: begin
                a_d = pc;
                b_d = 32'd4;
            end
            default: ;
        endcase
    end

`ifdef ALU_ISSUE_ILLEGAL_EN
    logic [6:0] f7;
    assign f7 = instr[31:25];
    always_comb begin
        case (opc)
            OPC_OP:     bad = !(f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)));
            OPC_OP_IMM: bad = (f3 == 3'b001 && f7 != F7_BASE) ||
                              (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT);
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: bad = 1'b0;
            default:    bad = 1'b1;
        endcase
    end
`else
    assign bad = 1'b0;
`endif

    assign illegal = bad;
    assign m       = bad ? ALU_ADD : m_d;
    assign a       = bad ? '0 : a_d;
    assign b       = bad ? '0 : b_d;
    assign wen     = !bad && rd != 5'd0;
endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: ALU issue stage with registered output and one-entry skid buffer
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready with in_instr, in_pc,
// in_rs1_val, in_rs2_val; out_valid/out_ready with out_m, out_a, out_b, out_rd,
// out_wen, out_illegal. Illegal detection is enabled by ALU_ISSUE_ILLEGAL_EN.
module alu_op_issue
    import kisc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_m,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic            out_illegal
);
    logic [3:0]  d_m;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic [4:0]  d_rd;
    logic        d_wen;
    logic        d_ill;
    alu_entry_t  dec;
    alu_entry_t  out_q;
    alu_entry_t  skid_q;
    logic        acc;

    alu_op_decode u_dec (
        .instr   (in_instr),
        .pc      (in_pc),
        .rs1     (in_rs1_val),
        .rs2     (in_rs2_val),
        .m       (d_m),
        .a       (d_a),
        .b       (d_b),
        .rd      (d_rd),
        .wen     (d_wen),
        .illegal (d_ill)
    );

    assign dec = {d_m, d_a, d_b, d_rd, d_wen, d_ill};
    assign acc = in_valid && in_ready;

    // in_ready doubles as "skid empty": the skid holds an entry exactly when it is low.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_q     <= '0;
            skid_q    <= '0;
        end else if (!out_valid || out_ready) begin
            out_valid <= !in_ready || acc;
            in_ready  <= 1'b1;
            if (!in_ready) out_q <= skid_q;
            else if (acc) out_q <= dec;
        end else if (acc) begin
            skid_q   <= dec;
            in_ready <= 1'b0;
        end
    end

    assign out_m       = out_q.m;
    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_rd      = out_q.rd;
    assign out_wen     = out_q.wen;
    assign out_illegal = out_q.illegal;
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: scoreboard bench for the ALU issue stage
module tb_alu_op_issue;
    typedef struct packed {
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        exp_t        exp;
    } vec_t;

    logic        clk = 0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val, out_a, out_b;
    logic [3:0]  out_m;
    logic [4:0]  out_rd;
    logic        out_wen, out_illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t cur_exp;
    exp_t sb[$];
    vec_t tv[$];
    vec_t i0, i1, i2;
    logic done;

    alu_op_issue dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_val  (in_rs1_val),
        .in_rs2_val  (in_rs2_val),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_m       (out_m),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_rd      (out_rd),
        .out_wen     (out_wen),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, pc, rs1, rs2,
                                input logic [3:0] m, input logic [31:0] a, b,
                                input logic [4:0] rd, input logic wen, ill);
        vec_t v;
        v.instr = instr; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2;
        v.exp = '{m: m, a: a, b: b, rd: rd, wen: wen, ill: ill};
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1; in_instr = v.instr; in_pc = v.pc;
        in_rs1_val = v.rs1; in_rs2_val = v.rs2; cur_exp = v.exp;
    endtask

    task automatic idle();
        in_valid = 0;
    endtask

    task automatic send(input vec_t v);
        logic took;
        took = 0;
        drive(v);
        for (int n = 0; n < 50 && !took; n++) begin
            @(negedge clk);
            took = in_ready;
            step();
        end
        if (!took) chk("send_timeout", {31'd0, took}, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst || flush) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_out", {31'd0, out_valid}, 0);
                else begin
                    e = sb.pop_front();
                    chk("m", {28'd0, out_m}, {28'd0, e.m});
                    chk("a", out_a, e.a);
                    chk("b", out_b, e.b);
                    chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
                    chk("wen", {31'd0, out_wen}, {31'd0, e.wen});
                    chk("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    initial begin
        tv.push_back(mk(32'h002081B3, 0, 5, 7, 4'h0, 5, 7, 3, 1, 0));
        tv.push_back(mk(32'h402081B3, 0, 5, 7, 4'h8, 5, 7, 3, 1, 0));
        tv.push_back(mk(32'h40335293, 0, 32'h80000000, 9, 4'hD, 32'h80000000, 32'h403, 5, 1, 0));
        tv.push_back(mk(32'hFFF00093, 0, 32'h11, 9, 4'h0, 32'h11, 32'hFFFFFFFF, 1, 1, 0));
        tv.push_back(mk(32'h123450B7, 0, 32'h55, 9, 4'h0, 0, 32'h12345000, 1, 1, 0));
        tv.push_back(mk(32'h00001217, 32'h100, 32'h55, 9, 4'h0, 32'h100, 32'h1000, 4, 1, 0));
        tv.push_back(mk(32'h00208033, 0, 1, 2, 4'h0, 1, 2, 0, 0, 0));
        tv.push_back(mk(32'h000000EF, 32'h200, 1, 2, 4'h0, 32'h200, 4, 1, 1, 0));
`ifdef ALU_ISSUE_ILLEGAL_EN
        tv.push_back(mk(32'h40119113, 0, 9, 3, 4'h0, 0, 0, 2, 0, 1));
        tv.push_back(mk(32'h0000008B, 0, 9, 3, 4'h0, 0, 0, 1, 0, 1));
        tv.push_back(mk(32'h022081B3, 0, 9, 3, 4'h0, 0, 0, 3, 0, 1));
`else
        tv.push_back(mk(32'h40119113, 0, 9, 3, 4'h1, 9, 32'h401, 2, 1, 0));
        tv.push_back(mk(32'h0000008B, 0, 9, 3, 4'h0, 9, 3, 1, 1, 0));
        tv.push_back(mk(32'h022081B3, 0, 9, 3, 4'h0, 9, 3, 3, 1, 0));
`endif
        i0 = mk(32'h002081B3, 0, 32'h10, 1, 4'h0, 32'h10, 1, 3, 1, 0);
        i1 = mk(32'h002081B3, 0, 32'h20, 2, 4'h0, 32'h20, 2, 3, 1, 0);
        i2 = mk(32'h002081B3, 0, 32'h30, 3, 4'h0, 32'h30, 3, 3, 1, 0);

        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        in_instr = 0; in_pc = 0; in_rs1_val = 0; in_rs2_val = 0; cur_exp = '0;
        repeat (2) step();
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_m", {28'd0, out_m}, 0);
        chk("rst_a", out_a, 0);
        chk("rst_b", out_b, 0);
        chk("rst_rd_wen_ill", {27'd0, out_rd, out_wen, out_illegal}, 0);
        rst = 0;

        out_ready = 1;
        foreach (tv[i]) begin
            send(tv[i]);
            chk("latency_valid", {31'd0, out_valid}, 1);
        end
        idle();
        step();
        chk("drained_valid", {31'd0, out_valid}, 0);

        out_ready = 0;
        drive(i0); step();
        chk("bp_valid", {31'd0, out_valid}, 1);
        chk("bp_a_i0", out_a, 32'h10);
        drive(i1); step();
        chk("bp_ready_low", {31'd0, in_ready}, 0);
        drive(i2);
        repeat (2) begin
            step();
            chk("bp_hold_a", out_a, 32'h10);
            chk("bp_hold_b", out_b, 1);
            chk("bp_ready_held", {31'd0, in_ready}, 0);
        end
        out_ready = 1;
        step();
        chk("bp_out_i1", out_a, 32'h20);
        chk("bp_ready_back", {31'd0, in_ready}, 1);
        step();
        idle();
        chk("bp_out_i2", out_a, 32'h30);
        step();
        chk("bp_empty", {31'd0, out_valid}, 0);

        out_ready = 0;
        drive(i0); step();
        drive(i1); step();
        chk("fl_full", {31'd0, in_ready}, 0);
        flush = 1; drive(i2); step();
        flush = 0; idle();
        chk("fl_valid", {31'd0, out_valid}, 0);
        chk("fl_ready", {31'd0, in_ready}, 1);
        chk("fl_a", out_a, 0);
        out_ready = 1;
        flush = 1; drive(i2); step();
        flush = 0; idle(); step();
        chk("fl_drop_input", {31'd0, out_valid}, 0);

        out_ready = 0;
        drive(i0); step();
        drive(i1); step();
        rst = 1; flush = 1; idle(); step();
        rst = 0; flush = 0;
        chk("rs_valid", {31'd0, out_valid}, 0);
        chk("rs_ready", {31'd0, in_ready}, 1);
        chk("rs_m", {28'd0, out_m}, 0);
        out_ready = 1;
        step();
        chk("rs_stay_empty", {31'd0, out_valid}, 0);

        done = 0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    send(tv[$urandom_range(0, tv.size() - 1)]);
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        step();
                    end
                end
                idle();
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = $urandom_range(0, 1) == 1;
                    step();
                end
            end
        join
        out_ready = 1;
        repeat (5) step();
        chk("sb_drained", sb.size(), 0);
        chk("final_valid", {31'd0, out_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
